instr_fetch_ctrl: RTL and testbench

//   Sequencer and sole owner of the program memory port (comb read, sync write on w_en).

---
 rtl/instr_fetch_ctrl_pkg.sv | 20 ++
 rtl/instr_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encodings
// and the instruction-word constants used when screening fetched words.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE  = 2'd0,
    FETCH_ST_BOOT  = 2'd1,
    FETCH_ST_FETCH = 2'd2,
    FETCH_ST_HALT  = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_WIDTH   = 32;
  localparam logic [31:0] INSTR_INVALID = 32'h0000_0000;

  // An all-zero word is reserved as the invalid opcode.
  function automatic logic is_invalid_op(input logic [INSTR_WIDTH-1:0] word);
    return (word == INSTR_INVALID);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Boot loader / instruction fetch sequencer owning the program memory port.
// Optional build macro HALT_ON_ZERO_EN: a fetched all-zero word halts the core.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_start,
  input  logic                run_start,
  input  logic                boot_valid,
  input  logic [31:0]         boot_data,
  input  logic                boot_last,
  output logic                boot_ready,
  output logic                mem_w_en,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr_data,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                halted,
  output logic [PC_WIDTH-1:0] boot_count
);

`ifdef HALT_ON_ZERO_EN
  localparam bit HaltOnZero = 1'b1;
`else
  localparam bit HaltOnZero = 1'b0;
`endif

  localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] PcMax = {PC_WIDTH{1'b1}};

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [PC_WIDTH-1:0] boot_count_q, boot_count_d;
  logic                instr_valid_q, instr_valid_d;
  logic [31:0]         instr_data_q, instr_data_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                in_boot_s;

  assign in_boot_s  = (state_q == FETCH_ST_BOOT);
  assign boot_ready = in_boot_s;
  assign mem_w_en   = in_boot_s & boot_valid;
  assign mem_addr   = in_boot_s ? load_ptr_q : pc_q;
  assign mem_wdata  = boot_data;
  assign halted     = (state_q == FETCH_ST_HALT);

  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign boot_count  = boot_count_q;

  // Next-state logic for the sequencer, load pointer and decode output slot.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_ptr_d    = load_ptr_q;
    boot_count_d  = boot_count_q;
    instr_valid_d = instr_valid_q;
    instr_data_d  = instr_data_q;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      FETCH_ST_IDLE, FETCH_ST_HALT: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
        end else begin
          instr_valid_d = instr_valid_q;
        end
        // Boot wins over run; a reboot drops any instruction still on offer.
        if (boot_start) begin
          state_d       = FETCH_ST_BOOT;
          load_ptr_d    = '0;
          boot_count_d  = '0;
          instr_valid_d = 1'b0;
        end else if (run_start) begin
          state_d = FETCH_ST_FETCH;
          pc_d    = RESET_PC;
        end else begin
          state_d = state_q;
        end
      end

      FETCH_ST_BOOT: begin
        if (boot_valid) begin
          load_ptr_d = load_ptr_q + PcOne;
          if (boot_count_q != PcMax) begin
            boot_count_d = boot_count_q + PcOne;
          end else begin
            boot_count_d = boot_count_q;
          end
          // The last memory word ends the boot even without boot_last.
          if (boot_last || (load_ptr_q == PcMax)) begin
            state_d = FETCH_ST_IDLE;
          end else begin
            state_d = FETCH_ST_BOOT;
          end
        end else begin
          state_d = FETCH_ST_BOOT;
        end
      end

      FETCH_ST_FETCH: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
        end else if (!instr_valid_q || instr_ready) begin
          if (HaltOnZero && is_invalid_op(mem_rdata)) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH_ST_HALT;
          end else begin
            instr_data_d  = mem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PcOne;
          end
        end else begin
          instr_valid_d = instr_valid_q;
        end
      end

      default: begin
        state_d = FETCH_ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_ST_IDLE;
      pc_q          <= RESET_PC;
      load_ptr_q    <= '0;
      boot_count_q  <= '0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      load_ptr_q    <= load_ptr_d;
      boot_count_q  <= boot_count_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: boot loading, fetch handshake,
// redirect, wrap and the optional halt-on-zero build (HALT_ON_ZERO_EN).
module tb_instr_fetch_ctrl;

  localparam int PCW   = 12;
  localparam int DEPTH = 1 << PCW;

  logic           clk = 1'b0;
  logic           rst, boot_start, run_start, boot_valid, boot_last;
  logic [31:0]    boot_data;
  logic           boot_ready, mem_w_en;
  logic [PCW-1:0] mem_addr;
  logic [31:0]    mem_wdata, mem_rdata;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           instr_valid, instr_ready;
  logic [31:0]    instr_data;
  logic [PCW-1:0] instr_pc;
  logic           halted;
  logic [PCW-1:0] boot_count;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.PC_WIDTH(PCW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start), .run_start(run_start),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .halted(halted),
    .boot_count(boot_count)
  );

  // Program memory environment: written only through the DUT port.
  logic [31:0] pmem [DEPTH];
  logic        mem_init;
  assign mem_rdata = pmem[mem_addr];

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) pmem[i] <= init_word(i);
    end else if (mem_w_en) begin
      pmem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [31:0]    ref_mem [DEPTH];
  logic [31:0]    bw [DEPTH];
  logic [PCW-1:0] exp_pc;
  int             exp_valid;
  bit             stall_prev;
  logic [PCW-1:0] hold_pc;
  logic [31:0]    hold_data;
  int             n_checks = 0;
  int             n_errors = 0;
  int             delivered;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Boot n words from bw[], optional boot_last on the final one, random gaps.
  task automatic boot_seq(input int n, input bit use_last);
    int i;
    boot_start = 1'b1;
    cyc();
    boot_start = 1'b0;
    check_eq("boot_entry_ready", boot_ready, 1);
    check_eq("boot_entry_count", boot_count, 0);
    i = 0;
    while (i < n) begin
      if ($urandom_range(0, 3) == 0) begin
        boot_valid = 1'b0;
        #1;
        check_eq("boot_gap_wen", mem_w_en, 0);
        check_eq("boot_gap_ready", boot_ready, 1);
      end else begin
        boot_valid = 1'b1;
        boot_data  = bw[i];
        boot_last  = use_last && (i == n - 1);
        #1;
        check_eq("boot_wen", mem_w_en, 1);
        check_eq("boot_addr", mem_addr, 64'(i));
        check_eq("boot_wdata", mem_wdata, bw[i]);
        ref_mem[i] = bw[i];
        i++;
      end
      cyc();
    end
    boot_valid = 1'b0;
    boot_last  = 1'b0;
    check_eq("boot_exit_ready", boot_ready, 0);
    check_eq("boot_final_count", boot_count, 64'((n > DEPTH - 1) ? DEPTH - 1 : n));
  endtask

  task automatic start_run();
    run_start = 1'b1;
    cyc();
    run_start  = 1'b0;
    exp_pc     = '0;
    exp_valid  = 0;
    stall_prev = 1'b0;
  endtask

  // One FETCH cycle: decode side behaviour plus in-order delivery scoreboard.
  task automatic fetch_cycle(input bit rdy, input bit rv, input logic [PCW-1:0] rp);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    check_eq("not_halted", halted, 0);
    if (exp_valid >= 0) check_eq("valid_timing", instr_valid, 64'(exp_valid));
    if (stall_prev) begin
      check_eq("stall_valid", instr_valid, 1);
      check_eq("stall_pc", instr_pc, hold_pc);
      check_eq("stall_data", instr_data, hold_data);
      check_eq("stall_fetch_addr", mem_addr, 64'(PCW'(hold_pc + 1)));
    end
    stall_prev = 1'b0;
    if (rv) begin
      exp_pc = rp;
    end else if (instr_valid && rdy) begin
      check_eq("deliver_pc", instr_pc, exp_pc);
      check_eq("deliver_data", instr_data, ref_mem[exp_pc]);
      exp_pc = exp_pc + 1'b1;
    end else if (instr_valid) begin
      stall_prev = 1'b1;
      hold_pc    = instr_pc;
      hold_data  = instr_data;
    end
    exp_valid = rv ? 0 : 1;
    cyc();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; boot_start = 1'b0; run_start = 1'b0; boot_valid = 1'b0;
    boot_last = 1'b0; boot_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; mem_init = 1'b1;
    exp_pc = '0; exp_valid = -1; stall_prev = 1'b0; hold_pc = '0; hold_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    cyc();
    mem_init = 1'b0;
    cyc();
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_data", instr_data, 0);
    check_eq("rst_pc", instr_pc, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_boot_ready", boot_ready, 0);
    check_eq("rst_wen", mem_w_en, 0);
    check_eq("rst_boot_count", boot_count, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    cyc();

    // Three-word boot, then fetch with a stall at instr_pc 1.
    bw[0] = 32'hA; bw[1] = 32'hB; bw[2] = 32'hC;
    boot_seq(3, 1'b1);
    start_run();
    fetch_cycle(1'b1, 1'b0, '0);
    fetch_cycle(1'b1, 1'b0, '0);
    check_eq("stall_at_pc1", instr_pc, 1);
    repeat (4) fetch_cycle(1'b0, 1'b0, '0);
    repeat (3) fetch_cycle(1'b1, 1'b0, '0);

    // Redirect while an instruction is on offer but not taken.
    fetch_cycle(1'b0, 1'b0, '0);
    fetch_cycle(1'b0, 1'b1, 12'h040);
    fetch_cycle(1'b0, 1'b0, '0);
    check_eq("redirect_target", instr_pc, 12'h040);
    repeat (3) fetch_cycle(1'b1, 1'b0, '0);

    // PC wrap from the top of memory.
    fetch_cycle(1'b1, 1'b1, PCW'(DEPTH - 2));
    repeat (5) fetch_cycle(1'b1, 1'b0, '0);

    // Random decode backpressure and redirects.
    for (int c = 0; c < 400; c++) begin
      logic [PCW-1:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? PCW'(DEPTH - 1 - $urandom_range(0, 2))
                                       : PCW'($urandom_range(0, DEPTH - 1));
      fetch_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rp);
    end

    // Reset in the middle of a boot keeps already written words.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    boot_start = 1'b1; cyc(); boot_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      boot_valid = 1'b1; boot_data = 32'h5150_0000 | 32'(i); #1;
      ref_mem[i] = boot_data;
      cyc();
    end
    boot_valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("midboot_rst_ready", boot_ready, 0);
    check_eq("midboot_rst_count", boot_count, 0);
    cyc();

    // Zero word at address 3.
    bw[0] = 32'h11; bw[1] = 32'h22; bw[2] = 32'h33; bw[3] = 32'h0;
    boot_seq(4, 1'b1);
`ifdef HALT_ON_ZERO_EN
    start_run();
    delivered = 0;
    for (int c = 0; c < 8; c++) begin
      instr_ready = 1'b1;
      #1;
      if (instr_valid) begin
        check_eq("zero_pc", instr_pc, 64'(delivered));
        check_eq("zero_data", instr_data, ref_mem[delivered]);
        delivered++;
      end
      cyc();
    end
    instr_ready = 1'b0;
    check_eq("zero_delivered", 64'(delivered), 3);
    check_eq("zero_halted", halted, 1);
    check_eq("zero_valid", instr_valid, 0);
    start_run();
    repeat (3) fetch_cycle(1'b1, 1'b0, '0);
`else
    start_run();
    repeat (6) fetch_cycle(1'b1, 1'b0, '0);
    check_eq("zero_no_halt", halted, 0);
`endif

    // Full-depth boot without boot_last stops at the last address.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int i = 0; i < DEPTH; i++) bw[i] = $urandom | 32'h1;
    boot_seq(DEPTH, 1'b0);
    cyc();
    check_eq("fullboot_idle", boot_ready, 0);
    start_run();
    for (int c = 0; c < 100; c++) begin
      fetch_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  PCW'($urandom_range(0, DEPTH - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
